spi_frame_decoder: RTL and testbench
====================================

# spi_frame_decoder

Consumes the 16-bit parallel word built by the SPI shift-in register and turns each chip-select frame into register writes. It sits directly downstream of the shift register, using the same chip-select and the same system clock. It decodes a command word and then a stream of data words. It drives a write port into the LED frame buffer, plus one control register used by the LED controller.

## Interface
Parameters:
- WORD_W, 16, SPI word width; must match the shift register's q width
- ADDR_W, 12, frame-buffer address width; opcode width is WORD_W-ADDR_W (4)

Ports:
- clock  in  1  system clock; the shift register shifts on this same clock while enabled
- nReset  in  1  synchronous, active-low reset
- ncs  in  1  SPI chip select, active low; the shift register is enabled exactly while ncs=0
- spi_word  in  WORD_W  parallel output of the shift register
- wr_en  out  1  one-cycle frame-buffer write strobe
- wr_addr  out  ADDR_W  frame-buffer write address
- wr_data  out  WORD_W  frame-buffer write data
- ctrl_reg  out  WORD_W  LED control register
- frame_done  out  1  one-cycle pulse at the end of a frame that performed at least one write
- cmd_err  out  1  one-cycle pulse when the command word carries an unsupported opcode

## Operation
- The bit counter is 4 bits and cleared while ncs=1. It increments on every clock edge with ncs=0.
- On the edge where the counter goes 15→0, the shift register has just captured the 16th bit. That edge sets word_rdy, which is registered.
- In the cycle where word_rdy=1, spi_word holds the complete word. The FSM consumes it in that cycle.
- State IDLE:
  - stays while ncs=1
  - ncs=0 → CMD
- State CMD, on word_rdy, decode the opcode in spi_word[15:12]:
  - 0x0 NOP → DISCARD
  - 0x1 WRITE: addr_q ← spi_word[11:0] → WR
  - 0x2 CTRL → CTRLW
  - any other opcode: pulse cmd_err → DISCARD
- State WR, on each word_rdy:
  - assert wr_en next cycle with wr_addr=addr_q and wr_data=the word
  - addr_q ← addr_q+1, modulo 2^ADDR_W (0xFFF wraps to 0x000)
  - set the wrote flag
- State CTRLW, on word_rdy: ctrl_reg ← word, set the wrote flag → DISCARD. Further words in the frame are ignored.
- State DISCARD: ignores word_rdy until ncs rises.
- ncs=1 in any state:
  - next state IDLE
  - counter cleared; a partial word is dropped silently
  - if the wrote flag is set, pulse frame_done and clear the flag
- ncs rises on the same edge as word_rdy: the completed word is still consumed, and frame_done follows one cycle later.
- wr_addr and wr_data hold their last value when wr_en=0.

## Timing
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0
  - ctrl_reg=0x0000
  - frame_done=0, cmd_err=0
  - state=IDLE, counter=0, wrote=0
- Reset takes priority over all other activity. Reset during a frame aborts it with no frame_done.
- Latency from the 16th enabled edge:
  - word_rdy is +1 cycle
  - wr_en, ctrl_reg update, and cmd_err are +2 cycles
- Maximum sustained rate is one write per 16 cycles; no backpressure exists.
- frame_done is asserted in the cycle after the first edge at which ncs=1 is sampled.

## Structure
- Shared package spi_pkg holds:
  - the opcode enum (OP_NOP=0, OP_WRITE=1, OP_CTRL=2)
  - the state enum (IDLE, CMD, WR, CTRLW, DISCARD)
  - WORD_W and ADDR_W defaults
- One natural sub-module: spi_word_counter, containing the bit counter and word_rdy generation.
- The FSM and output registers stay in spi_frame_decoder.

## Test plan
- Reset: hold nReset=0 for 3 cycles with ncs toggling → all outputs 0, no strobes.
- Burst write: frame 0x1010, 0xAAAA, 0x5555 →
  - wr_en at addr 0x010 with data 0xAAAA, then addr 0x011 with 0x5555, each 2 cycles after the respective 16th bit
  - one frame_done after ncs rises
- Wrap: frame 0x1FFF, 0x0001, 0x0002 → writes to 0xFFF then 0x000.
- Control: frame 0x2000, 0x00C3, 0xFFFF → ctrl_reg=0x00C3; the third word is ignored; one frame_done.
- Bad opcode: frame 0x8DF3 → cmd_err pulses once; no wr_en, no frame_done.
- Abort: frame 0x1020, then 9 bits of a data word, then ncs rises → no wr_en, no frame_done, state IDLE. The next frame decodes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI frame decoder.
package spi_pkg;

   localparam int DEF_WORD_W = 16;
   localparam int DEF_ADDR_W = 12;

   typedef enum logic [3:0] {
      OP_NOP   = 4'h0,
      OP_WRITE = 4'h1,
      OP_CTRL  = 4'h2
   } opcode_t;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WR,
      CTRLW,
      DISCARD
   } state_t;

endpackage

// File: rtl/spi_word_counter.sv
// Counts enabled clock edges within a chip-select frame and flags each completed word.
module spi_word_counter
   import spi_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic clock,
   input  logic nReset,
   input  logic ncs,
   output logic word_rdy
);

   localparam int CNT_W = $clog2(WORD_W);

   logic [CNT_W-1:0] cnt_reg;

   // word_rdy rises on the edge where the counter wraps, i.e. the shift
   // register has just captured the last bit of the word.
   always_ff @(posedge clock) begin
      if (!nReset) begin
         cnt_reg  <= '0;
         word_rdy <= 1'b0;
      end else if (ncs) begin
         cnt_reg  <= '0;
         word_rdy <= 1'b0;
      end else begin
         cnt_reg  <= cnt_reg + 1'b1;
         word_rdy <= (cnt_reg == CNT_W'(WORD_W - 1));
      end
   end

endmodule

// File: rtl/spi_frame_decoder.sv
// Decodes each chip-select frame (command word + data words) into frame-buffer
// writes or a control-register update.
module spi_frame_decoder
   import spi_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              nReset,
   input  logic              ncs,
   input  logic [WORD_W-1:0] spi_word,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic [WORD_W-1:0] ctrl_reg,
   output logic              frame_done,
   output logic              cmd_err
);

   localparam int OP_W = WORD_W - ADDR_W;

   logic              word_rdy;
   logic [OP_W-1:0]   opcode;
   state_t            state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              wrote_reg;

   spi_word_counter #(
      .WORD_W (WORD_W)
   ) u_counter (
      .clock    (clock),
      .nReset   (nReset),
      .ncs      (ncs),
      .word_rdy (word_rdy)
   );

   assign opcode = spi_word[WORD_W-1 -: OP_W];

   always_ff @(posedge clock) begin
      if (!nReset) begin
         state_reg  <= IDLE;
         addr_reg   <= '0;
         wrote_reg  <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         ctrl_reg   <= '0;
         frame_done <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         cmd_err    <= 1'b0;

         if (word_rdy) begin
            case (state_reg)
               CMD: begin
                  case (opcode)
                     OP_W'(OP_NOP): state_reg <= DISCARD;
                     OP_W'(OP_WRITE): begin
                        addr_reg  <= spi_word[ADDR_W-1:0];
                        state_reg <= WR;
                     end
                     OP_W'(OP_CTRL): state_reg <= CTRLW;
                     default: begin
                        cmd_err   <= 1'b1;
                        state_reg <= DISCARD;
                     end
                  endcase
               end
               WR: begin
                  wr_en     <= 1'b1;
                  wr_addr   <= addr_reg;
                  wr_data   <= spi_word;
                  addr_reg  <= addr_reg + 1'b1;
                  wrote_reg <= 1'b1;
               end
               CTRLW: begin
                  ctrl_reg  <= spi_word;
                  wrote_reg <= 1'b1;
                  state_reg <= DISCARD;
               end
               default: ;
            endcase
         end else if (state_reg == IDLE && !ncs) begin
            state_reg <= CMD;
         end

         // A word completing as ncs rises is still consumed above; its
         // frame_done is deferred one cycle so the wrote flag is seen.
         if (ncs) begin
            state_reg <= IDLE;
            if (wrote_reg && !word_rdy) begin
               frame_done <= 1'b1;
               wrote_reg  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed, table-driven bench for spi_frame_decoder with an inline bit-serial shift-register model.
module tb_spi_frame_decoder;

   localparam int WORD_W = 16;
   localparam int ADDR_W = 12;

   logic              clock = 1'b0;
   logic              nReset = 1'b0;
   logic              ncs = 1'b1;
   logic [WORD_W-1:0] spi_word = '0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;
   logic [WORD_W-1:0] ctrl_reg;
   logic              frame_done;
   logic              cmd_err;

   spi_frame_decoder #(
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clock      (clock),
      .nReset     (nReset),
      .ncs        (ncs),
      .spi_word   (spi_word),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .ctrl_reg   (ctrl_reg),
      .frame_done (frame_done),
      .cmd_err    (cmd_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      string            name;
      logic [3:0][15:0] words;
      int               nwords;
      logic [15:0]      tail_word;
      int               tail;
      int               hold;
      int               nwr;
      logic [2:0][11:0] waddr;
      logic [2:0][15:0] wdata;
      logic [15:0]      ctrl;
      int               fd;
      int               ce;
   } vec_t;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int fd_cnt, ce_cnt, fd_cyc, ce_cyc;
   logic [11:0] wa_q[$];
   logic [15:0] wd_q[$];
   int          wc_q[$];
   int          b16_q[$];

   always @(negedge clock) begin
      cyc++;
      if (wr_en) begin
         wa_q.push_back(wr_addr);
         wd_q.push_back(wr_data);
         wc_q.push_back(cyc);
      end
      if (frame_done) begin
         fd_cnt++;
         fd_cyc = cyc;
      end
      if (cmd_err) begin
         ce_cnt++;
         ce_cyc = cyc;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      fd_cnt = 0; ce_cnt = 0; fd_cyc = -1; ce_cyc = -1;
      wa_q.delete(); wd_q.delete(); wc_q.delete(); b16_q.delete();
   endtask

   // Shift-register model: one bit enters per enabled edge, MSB first.
   task automatic shift_bits(input logic [15:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         ncs = 1'b0;
         @(posedge clock);
         #1;
         spi_word = {spi_word[WORD_W-2:0], w[15-i]};
         if (i == 15) b16_q.push_back(cyc);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input int nw, input logic [15:0] tw,
                               input int tl, input int hold, input int nwr,
                               input logic [11:0] a0, input logic [11:0] a1,
                               input logic [15:0] d0, input logic [15:0] d1,
                               input logic [15:0] ctrl, input int fd, input int ce);
      vec_t v;
      v.name = name;
      v.words = '0;
      v.words[0] = w0; v.words[1] = w1; v.words[2] = w2;
      v.nwords = nw; v.tail_word = tw; v.tail = tl; v.hold = hold; v.nwr = nwr;
      v.waddr = '0; v.waddr[0] = a0; v.waddr[1] = a1;
      v.wdata = '0; v.wdata[0] = d0; v.wdata[1] = d1;
      v.ctrl = ctrl; v.fd = fd; v.ce = ce;
      return v;
   endfunction

   task automatic run_frame(input vec_t v);
      int last;
      @(posedge clock);
      #1;
      clear_mon();
      for (int k = 0; k < v.nwords; k++) shift_bits(v.words[k], 16);
      if (v.tail > 0) shift_bits(v.tail_word, v.tail);
      repeat (v.hold) @(negedge clock);
      @(negedge clock);
      ncs = 1'b1;
      repeat (5) @(negedge clock);

      check({v.name, "_wr_count"}, wa_q.size(), v.nwr);
      for (int k = 0; k < v.nwr && k < wa_q.size(); k++) begin
         check($sformatf("%s_wr_addr%0d", v.name, k), wa_q[k], v.waddr[k]);
         check($sformatf("%s_wr_data%0d", v.name, k), wd_q[k], v.wdata[k]);
         check($sformatf("%s_wr_lat%0d", v.name, k), wc_q[k] - b16_q[k+1], 2);
      end
      check({v.name, "_ctrl_reg"}, ctrl_reg, v.ctrl);
      check({v.name, "_frame_done"}, fd_cnt, v.fd);
      check({v.name, "_cmd_err"}, ce_cnt, v.ce);
      if (v.ce > 0 && ce_cnt > 0) check({v.name, "_cmd_err_lat"}, ce_cyc - b16_q[0], 2);
      if (v.nwr > 0 && wa_q.size() > 0) begin
         last = v.nwr - 1;
         check({v.name, "_wr_addr_hold"}, wr_addr, v.waddr[last]);
         check({v.name, "_wr_data_hold"}, wr_data, v.wdata[last]);
         if (v.hold == 0 && fd_cnt > 0) check({v.name, "_fd_after_wr"}, fd_cyc - wc_q[wc_q.size()-1], 1);
      end
   endtask

   vec_t vecs[8];

   initial begin
      //            name       w0       w1       w2       nw tail_w   tl hold nwr a0      a1      d0        d1        ctrl      fd ce
      vecs[0] = mk("burst",   16'h1010, 16'hAAAA, 16'h5555, 3, 16'h0, 0, 3, 2, 12'h010, 12'h011, 16'hAAAA, 16'h5555, 16'h0000, 1, 0);
      vecs[1] = mk("wrap",    16'h1FFF, 16'h0001, 16'h0002, 3, 16'h0, 0, 3, 2, 12'hFFF, 12'h000, 16'h0001, 16'h0002, 16'h0000, 1, 0);
      vecs[2] = mk("ctrl",    16'h2000, 16'h00C3, 16'hFFFF, 3, 16'h0, 0, 2, 0, 12'h000, 12'h000, 16'h0000, 16'h0000, 16'h00C3, 1, 0);
      vecs[3] = mk("badop",   16'h8DF3, 16'h0000, 16'h0000, 1, 16'h0, 0, 3, 0, 12'h000, 12'h000, 16'h0000, 16'h0000, 16'h00C3, 0, 1);
      vecs[4] = mk("abort",   16'h1020, 16'h0000, 16'h0000, 1, 16'h1234, 9, 0, 0, 12'h000, 12'h000, 16'h0000, 16'h0000, 16'h00C3, 0, 0);
      vecs[5] = mk("recover", 16'h1020, 16'hBEEF, 16'h0000, 2, 16'h0, 0, 2, 1, 12'h020, 12'h000, 16'hBEEF, 16'h0000, 16'h00C3, 1, 0);
      vecs[6] = mk("nop",     16'h0123, 16'h4444, 16'h0000, 2, 16'h0, 0, 2, 0, 12'h000, 12'h000, 16'h0000, 16'h0000, 16'h00C3, 0, 0);
      vecs[7] = mk("ncs_edge",16'h1050, 16'h7777, 16'h0000, 2, 16'h0, 0, 0, 1, 12'h050, 12'h000, 16'h7777, 16'h0000, 16'h00C3, 1, 0);

      // Reset held for three cycles with chip select toggling.
      clear_mon();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         ncs = (i % 2 == 0) ? 1'b0 : 1'b1;
         @(posedge clock);
         #1;
         check($sformatf("rst_wr_en%0d", i), wr_en, 0);
         check($sformatf("rst_frame_done%0d", i), frame_done, 0);
         check($sformatf("rst_cmd_err%0d", i), cmd_err, 0);
         check($sformatf("rst_wr_addr%0d", i), wr_addr, 0);
         check($sformatf("rst_wr_data%0d", i), wr_data, 0);
         check($sformatf("rst_ctrl%0d", i), ctrl_reg, 0);
      end
      @(negedge clock);
      ncs = 1'b1;
      nReset = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_no_strobes", wa_q.size() + fd_cnt + ce_cnt, 0);

      for (int t = 0; t < 8; t++) run_frame(vecs[t]);

      // Reset mid-frame after a write: frame aborted, no frame_done, ctrl cleared.
      @(posedge clock);
      #1;
      clear_mon();
      shift_bits(16'h1030, 16);
      shift_bits(16'h1111, 16);
      repeat (3) @(negedge clock);
      nReset = 1'b0;
      repeat (2) @(negedge clock);
      ncs = 1'b1;
      @(negedge clock);
      nReset = 1'b1;
      repeat (5) @(negedge clock);
      check("midrst_wr_count", wa_q.size(), 1);
      check("midrst_frame_done", fd_cnt, 0);
      check("midrst_ctrl", ctrl_reg, 0);
      check("midrst_wr_addr", wr_addr, 0);
      check("midrst_wr_data", wr_data, 0);

      run_frame(mk("post_rst", 16'h1007, 16'hCAFE, 16'h0000, 2, 16'h0, 0, 2, 1, 12'h007, 12'h000,
                   16'hCAFE, 16'h0000, 16'h0000, 1, 0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
